dual_rail_phase_seq: RTL

- Clocked source of dual-rail phase/command tokens (PH0, PH1, Rd, Ld) for the asynchronous CPU controller stage; sits directly upstream of it.
- Runs a four-phase return-to-zero handshake: drives a valid codeword, waits for the controller's R_m (and optionally R_c) outputs to become valid, drives the all-zero spacer, waits for them to return to null, then advances the phase.
- Bridges the synchronous test/bring-up domain into the delay-insensitive datapath.

---
 rtl/dual_rail_pkg.sv | 68 ++++++
 rtl/dr_sync2.sv | 33 +++
 rtl/dual_rail_phase_seq.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dual_rail_pkg.sv
// -----------------------------------------------------------------------------
// dual_rail_pkg
// Shared types and helpers for the dual-rail phase sequencer:
//   state_t      - sequencer FSM states
//   dr_status_t  - status of one dual-rail pair (null / valid / invalid)
//   dr_pair_t    - one dual-rail pair {t, f}
//   token_t      - the four pairs driven to the controller (PH0, PH1, Rd, Ld)
//   dr_encode()  - encode one bit as a valid dual-rail pair
//   dr_status()  - classify a pair from its two rails
//   make_token() - build a full codeword from phase and command bits
// -----------------------------------------------------------------------------
package dual_rail_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_SPACER = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DR_NULL    = 2'd0,
    DR_VALID   = 2'd1,
    DR_INVALID = 2'd2
  } dr_status_t;

  typedef struct packed {
    logic t;
    logic f;
  } dr_pair_t;

  typedef struct packed {
    dr_pair_t ph0;
    dr_pair_t ph1;
    dr_pair_t rd;
    dr_pair_t ld;
  } token_t;

  // All rails low: the return-to-zero spacer between codewords.
  localparam token_t TOKEN_SPACER = '0;

  function automatic dr_pair_t dr_encode(input logic b);
    dr_pair_t p;
    p.t = b;
    p.f = ~b;
    return p;
  endfunction

  function automatic dr_status_t dr_status(input logic t, input logic f);
    case ({t, f})
      2'b00:   return DR_NULL;
      2'b11:   return DR_INVALID;
      default: return DR_VALID;
    endcase
  endfunction

  function automatic token_t make_token(input logic [1:0] phase,
                                        input logic       rd,
                                        input logic       ld);
    token_t tok;
    tok.ph0 = dr_encode(phase[0]);
    tok.ph1 = dr_encode(phase[1]);
    tok.rd  = dr_encode(rd);
    tok.ld  = dr_encode(ld);
    return tok;
  endfunction

endpackage

// File: rtl/dr_sync2.sv
// -----------------------------------------------------------------------------
// dr_sync2
// Two-flop synchronizer for asynchronous dual-rail acknowledge rails.
// Ports:
//   clk - sampling clock
//   rst - asynchronous active-high reset, clears both stages to 0
//   d   - asynchronous input bits (WIDTH)
//   q   - synchronized output bits (WIDTH), two cycles behind d
// -----------------------------------------------------------------------------
module dr_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments make meta and q update together at the
  // edge, so q really is one stage behind meta rather than a copy of d.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dual_rail_phase_seq.sv
// -----------------------------------------------------------------------------
// dual_rail_phase_seq
// Clocked source of dual-rail phase/command tokens for the asynchronous CPU
// controller stage. Runs a four-phase return-to-zero handshake: codeword out,
// wait for R_m (and R_c when USE_RC=1) valid, spacer out, wait for null,
// advance the 2-bit phase.
// Parameters:
//   TIMEOUT - max cycles waiting in DATA or SPACER before ERROR (>= 2)
//   USE_RC  - 1: completion also needs the R_c pair; 0: R_m pair only
// Ports:
//   clk, rst                   - clock, asynchronous active-high reset
//   run                        - keep issuing tokens while high
//   rd_req, ld_req             - command bits latched into the next token
//   R_c_t/f, R_m_t/f           - asynchronous dual-rail acks from controller
//   PH0_t/f, PH1_t/f, Rd_t/f, Ld_t/f - registered dual-rail token
//   phase                      - current phase count {PH1,PH0}
//   busy                       - high in DATA or SPACER
//   err                        - sticky error flag, cleared only by rst
// Build option: define PHASE_SEQ_TIMEOUT_EN to enable the wait timeout;
// without it the sequencer waits indefinitely and TIMEOUT is unused.
// -----------------------------------------------------------------------------
module dual_rail_phase_seq
  import dual_rail_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int USE_RC  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       rd_req,
  input  logic       ld_req,
  input  logic       R_c_t,
  input  logic       R_c_f,
  input  logic       R_m_t,
  input  logic       R_m_f,
  output logic       PH0_t,
  output logic       PH0_f,
  output logic       PH1_t,
  output logic       PH1_f,
  output logic       Rd_t,
  output logic       Rd_f,
  output logic       Ld_t,
  output logic       Ld_f,
  output logic [1:0] phase,
  output logic       busy,
  output logic       err
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("dual_rail_phase_seq: TIMEOUT must be at least 2");
  end

  state_t     state;
  token_t     token;
  logic [3:0] ack_sync;
  dr_status_t m_status;
  dr_status_t c_status;
  logic       rc_used;
  logic       ack_valid;
  logic       ack_null;
  logic       ack_bad;
  logic       waiting;
  logic       wait_met;
  logic       wait_expired;
  logic       fault;

  dr_sync2 #(.WIDTH(4)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   ({R_c_t, R_c_f, R_m_t, R_m_f}),
    .q   (ack_sync)
  );

  // Completion detection works only on synchronized rails.
  assign m_status  = dr_status(ack_sync[1], ack_sync[0]);
  assign c_status  = dr_status(ack_sync[3], ack_sync[2]);
  assign rc_used   = (USE_RC != 0);
  assign ack_valid = (m_status == DR_VALID) && (!rc_used || c_status == DR_VALID);
  assign ack_null  = (m_status == DR_NULL)  && (!rc_used || c_status == DR_NULL);
  assign ack_bad   = (m_status == DR_INVALID) || (rc_used && c_status == DR_INVALID);

  // DATA waits for all monitored pairs valid, SPACER for all null.
  assign waiting  = (state == ST_DATA) || (state == ST_SPACER);
  assign wait_met = (state == ST_DATA) ? ack_valid : ack_null;

`ifdef PHASE_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Every DATA/SPACER entry happens on an edge where the previous wait was
  // met (or from IDLE), so clearing whenever not waiting-unmet restarts the
  // count at each entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (waiting && !wait_met) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign wait_expired = 1'b0;
`endif

  assign fault = waiting && (ack_bad || (!wait_met && wait_expired));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      token <= TOKEN_SPACER;
      phase <= 2'd0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else if (fault) begin
      state <= ST_ERROR;
      token <= TOKEN_SPACER;
      busy  <= 1'b0;
      err   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run && ack_null) begin
            state <= ST_DATA;
            token <= make_token(phase, rd_req, ld_req);
            busy  <= 1'b1;
          end
        end
        ST_DATA: begin
          if (ack_valid) begin
            state <= ST_SPACER;
            token <= TOKEN_SPACER;
          end
        end
        ST_SPACER: begin
          if (ack_null) begin
            phase <= phase + 2'd1;
            if (run) begin
              state <= ST_DATA;
              token <= make_token(phase + 2'd1, rd_req, ld_req);
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: ; // ST_ERROR: hold spacer and err until reset
      endcase
    end
  end

  assign PH0_t = token.ph0.t;
  assign PH0_f = token.ph0.f;
  assign PH1_t = token.ph1.t;
  assign PH1_f = token.ph1.f;
  assign Rd_t  = token.rd.t;
  assign Rd_f  = token.rd.f;
  assign Ld_t  = token.ld.t;
  assign Ld_f  = token.ld.f;

endmodule
